// File: rtl/sha256_msg_sequencer_if.sv
// Block-in / digest-out stream bundle for the SHA-256 message sequencer.
// master drives blocks and consumes digests; slave is the sequencer.
interface sha256_msg_sequencer_if;
    logic         blk_valid;
    logic [511:0] blk_data;
    logic         blk_last;
    logic         blk_ready;
    logic [255:0] digest;
    logic         digest_valid;
    logic         digest_ready;

    modport master (
        output blk_valid, blk_data, blk_last, digest_ready,
        input  blk_ready, digest, digest_valid
    );

    modport slave (
        input  blk_valid, blk_data, blk_last, digest_ready,
        output blk_ready, digest, digest_valid
    );
endinterface

// File: rtl/sha256_msg_sequencer.sv
// Drives one sha256_block core across a multi-block padded message,
// chaining H_out into H_in and presenting the final digest.
module sha256_msg_sequencer #(
    parameter int CORE_TIMEOUT = 127,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sha256_msg_sequencer_if.slave s,
    input  logic [255:0]         H_init,
    output logic [255:0]         core_H_in,
    output logic [511:0]         core_M_in,
    output logic                 core_start,
    input  logic [255:0]         core_H_out,
    input  logic                 core_done,
    output logic                 busy,
    output logic [CNT_W-1:0]     blk_count,
    output logic                 err_timeout,
    input  logic                 err_clr
);

    localparam int TW = $clog2(CORE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_OUT, S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic [255:0]     chain_q, chain_d;
    logic [255:0]     hin_q, hin_d;
    logic [511:0]     min_q, min_d;
    logic [255:0]     digest_q, digest_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             start_q, start_d;
    logic             dvalid_q, dvalid_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             accept;
    logic             err_set;

    assign accept = s.blk_valid & ready_q;

    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        last_d   = last_q;
        chain_d  = chain_q;
        hin_d    = hin_q;
        min_d    = min_q;
        digest_d = digest_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        err_set  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    min_d   = s.blk_data;
                    last_d  = s.blk_last;
                    hin_d   = first_q ? H_init : chain_q;
                    state_d = S_ISSUE;
                    if (first_q) cnt_d = '0;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                // a late core_done still counts even on the timeout cycle
                if (core_done) begin
                    chain_d = core_H_out;
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    if (last_q) begin
                        digest_d = core_H_out;
                        first_d  = 1'b1;
                        state_d  = S_OUT;
                    end else begin
                        first_d  = 1'b0;
                        state_d  = S_IDLE;
                    end
                end else if (timer_q == TW'(CORE_TIMEOUT - 1)) begin
                    err_set = 1'b1;
                    first_d = 1'b1;
                    state_d = last_q ? S_IDLE : S_DRAIN;
                end
            end
            S_OUT: begin
                if (s.digest_ready) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (accept && s.blk_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        err_d    = err_set | (err_q & ~err_clr);
        start_d  = (state_d == S_ISSUE);
        dvalid_d = (state_d == S_OUT);
        ready_d  = (state_d == S_IDLE) | (state_d == S_DRAIN);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            first_q  <= 1'b1;
            last_q   <= 1'b0;
            chain_q  <= '0;
            hin_q    <= '0;
            min_q    <= '0;
            digest_q <= '0;
            timer_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            dvalid_q <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            last_q   <= last_d;
            chain_q  <= chain_d;
            hin_q    <= hin_d;
            min_q    <= min_d;
            digest_q <= digest_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            start_q  <= start_d;
            dvalid_q <= dvalid_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign s.blk_ready    = ready_q;
    assign s.digest       = digest_q;
    assign s.digest_valid = dvalid_q;
    assign core_H_in      = hin_q;
    assign core_M_in      = min_q;
    assign core_start     = start_q;
    assign busy           = busy_q;
    assign blk_count      = cnt_q;
    assign err_timeout    = err_q;

endmodule

// File: doc/sha256_msg_sequencer.md
Name: sha256_msg_sequencer

Overview:
Controller that sequences the shared sha256_block compression core across a multi-block padded message. It accepts 512-bit padded blocks over a valid/ready stream and starts the core once per block. It chains each block's H_out into the next block's H_in, starting from the sha256_H_0 constant. It presents the final 256-bit digest on a valid/ready output, where the Hash160 top level consumes it and forwards it to the RIPEMD-160 stage.

Parameters:
CORE_TIMEOUT, 127, maximum WAIT-state cycles allowed for core output_valid before the message is aborted
CNT_W, 16, width of the per-message block counter (saturating)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets)
blk_valid  input  1  padded block available
blk_data  input  512  padded message block, big-endian word order as sha256_block M_in
blk_last  input  1  marks final block of message; qualified by blk_valid
blk_ready  output  1  sequencer accepts block this cycle
H_init  input  256  initial hash (tie to sha256_H_0.H_0)
core_H_in  output  256  to sha256_block H_in
core_M_in  output  512  to sha256_block M_in
core_start  output  1  to sha256_block input_valid, one-cycle pulse
core_H_out  input  256  from sha256_block H_out
core_done  input  1  from sha256_block output_valid
digest  output  256  final message hash
digest_valid  output  1  digest available
digest_ready  input  1  downstream consumes digest
busy  output  1  high in any state except IDLE
blk_count  output  CNT_W  blocks completed in current/last message
err_timeout  output  1  sticky core-timeout flag
err_clr  input  1  clears err_timeout

Behaviour:
- Reset (rst=0, async) forces:
  - state=IDLE, first=1, all data registers 0.
  - core_start=0, digest_valid=0, err_timeout=0, blk_count=0, busy=0.
  - blk_ready=1 from the first cycle after reset release.
- States are IDLE, ISSUE, WAIT, OUT, DRAIN.
- IDLE: blk_ready=1. On blk_valid&blk_ready:
  - core_M_in<=blk_data, last_r<=blk_last.
  - core_H_in<=(first ? H_init : chain).
  - If first: blk_count<=0.
  - Next state ISSUE.
- ISSUE: core_start=1 for exactly this one cycle; timer<=0; next state WAIT. blk_ready=0.
- WAIT: blk_ready=0; timer increments each cycle.
  - On core_done: chain<=core_H_out; blk_count increments, saturating at all-ones.
    - If last_r: digest<=core_H_out, first<=1, next state OUT.
    - Otherwise: first<=0, next state IDLE.
  - Else if timer==CORE_TIMEOUT-1: err_timeout<=1, first<=1.
    - If last_r: next state IDLE.
    - Otherwise: next state DRAIN.
  - If core_done and timeout coincide, core_done wins.
- OUT: digest_valid=1, with digest and digest_valid held stable until digest_ready. On digest_valid&digest_ready: next state IDLE. blk_ready=0.
- DRAIN: blk_ready=1. Accepted blocks are discarded and the core is not started. Accepting a block with blk_last=1 returns to IDLE.
- core_done outside WAIT is ignored; no state or register change.
- core_H_in and core_M_in are held constant from ISSUE through the end of WAIT.
- err_timeout is set only by timeout and cleared only by err_clr=1 or reset. Set has priority over a simultaneous clear.
- Latency:
  - Block accepted at edge k → core_start high during cycle k+1.
  - core_done sampled at edge j → digest_valid high from cycle j+1.
  - Next block can be accepted at edge j+1 when last_r=0.
- Reset mid-message aborts all state. The next accepted block uses H_init.
- Back-to-back messages: after OUT handshake, the next block always starts from H_init.

Test Plan:
- Single block "abc" (61626380 00…00 18) with blk_last=1 → one core_start pulse. Digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, blk_count=1.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (len 0x1C0) → second core_H_in equals first block's H_out. Digest 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, blk_count=2.
- Null message block (80…00, len 0) followed immediately by "abc" → digests e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855 then ba7816bf…15ad. The second message uses H_init.
- Hold digest_ready=0 for 10 cycles in OUT → digest and digest_valid stable, blk_ready=0, no core_start. Digest accepted on the first cycle digest_ready=1.
- Core stub never asserts core_done on block 1 of 3 → err_timeout=1 after 127 WAIT cycles. Blocks 2–3 are drained with no core_start. A subsequent "abc" message yields the correct digest. err_clr clears the flag.
- Assert rst=0 mid-WAIT of a two-block message → outputs return to reset values immediately. After release, "abc" produces ba7816bf…15ad.
